// File: rtl/lector_teclado.sv
// Row-side keypad receiver: aligns rows with the scanned column, accumulates
// per-frame hits and debounces whole frames into single key events.
module lector_teclado #(
  parameter int DEB_FRAMES = 3,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  input  logic [3:0] fil,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

  localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEB_FRAMES);

  logic [3:0] fil_s1, fil_s, fil_sd;
  logic [3:0] col_d1, col_d2, col_d3;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       cand, cand_n;
  logic             accept;

  logic       acc_hit, acc_multi;
  logic [3:0] acc_code;
  logic       s_hit, s_multi;
  logic [3:0] s_code;

  logic       phase_evt, col_ok, frame_end;
  logic [1:0] col_idx, row_idx;
  logic       row_one, row_multi;
  logic       res_single, res_none;

  // fil_sd is fil_s one cycle later so the row data matches col_d3,
  // the last settled cycle of the phase that is ending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fil_s1 <= '1;
      fil_s  <= '1;
      fil_sd <= '1;
      col_d1 <= '1;
      col_d2 <= '1;
      col_d3 <= '1;
    end else begin
      fil_s1 <= fil;
      fil_s  <= fil_s1;
      fil_sd <= fil_s;
      col_d1 <= col;
      col_d2 <= col_d1;
      col_d3 <= col_d2;
    end
  end

  always_comb begin
    col_ok  = 1'b1;
    col_idx = '0;
    case (col_d3)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_ok  = 1'b0;
    endcase
  end

  always_comb begin
    row_one   = 1'b1;
    row_multi = 1'b0;
    row_idx   = '0;
    case (fil_sd)
      4'b1111: row_one = 1'b0;
      4'b1110: row_idx = 2'd0;
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: begin
        row_one   = 1'b0;
        row_multi = 1'b1;
      end
    endcase
  end

  assign phase_evt = (col_d2 != col_d3);
  assign frame_end = phase_evt && col_ok && (col_d3 == 4'b0111);

  // Accumulator as it stands after folding in the current phase sample.
  always_comb begin
    s_hit   = acc_hit;
    s_multi = acc_multi;
    s_code  = acc_code;
    if (row_multi) begin
      s_multi = 1'b1;
    end else if (row_one) begin
      if (acc_hit) begin
        s_multi = 1'b1;
      end else begin
        s_hit  = 1'b1;
        s_code = {row_idx, col_idx};
      end
    end
  end

  assign res_single = s_hit && !s_multi;
  assign res_none   = !s_hit && !s_multi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_hit   <= 1'b0;
      acc_multi <= 1'b0;
      acc_code  <= '0;
    end else if (phase_evt) begin
      if (!col_ok || frame_end) begin
        acc_hit   <= 1'b0;
        acc_multi <= 1'b0;
        acc_code  <= '0;
      end else begin
        acc_hit   <= s_hit;
        acc_multi <= s_multi;
        acc_code  <= s_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key_valid <= accept;
      if (accept) key_code <= cand;
    end
  end

  assign cnt_inc = (cnt == DEB_C) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    accept  = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (res_single) begin
            state_n = CAND;
            cand_n  = s_code;
            cnt_n   = 'd1;
          end
        end
        CAND: begin
          if (res_single && s_code == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DEB_C) begin
              state_n = PRESSED;
              accept  = 1'b1;
            end
          end else if (res_single) begin
            cand_n = s_code;
            cnt_n  = 'd1;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        PRESSED: begin
          if (res_none) begin
            state_n = REL;
            cnt_n   = 'd1;
          end
        end
        REL: begin
          if (res_none) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DEB_C) state_n = IDLE;
          end else begin
            state_n = PRESSED;
            cnt_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    key_held = (state == PRESSED) || (state == REL);
  end

endmodule

// File: tb/tb_lector_teclado.sv
// Directed bench for lector_teclado: rotating column scan with a keypad model
// driving the rows, checking event count, code and timing per scenario.
module tb_lector_teclado;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col;
  logic [3:0]  fil;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;

  int tests, failed;
  int cyc, vcnt, vcyc, hrise, hfall, hfall_cnt, fidx;
  int fs [0:16];
  logic held_prev;

  lector_teclado #(.DEB_FRAMES(3), .CNT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col       (col),
    .fil       (fil),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] kp(input logic [3:0] c, input logic [15:0] k);
    logic [3:0] f;
    f = '1;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        if (!c[j] && k[r*4+j]) f[r] = 1'b0;
    return f;
  endfunction

  assign fil = kp(col, keys);

  initial begin
    cyc = 0; held_prev = 1'b0;
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (key_valid) begin
      vcnt++;
      vcyc = cyc;
    end
    if (key_held && !held_prev) hrise = cyc;
    if (!key_held && held_prev) begin
      hfall = cyc;
      hfall_cnt++;
    end
    held_prev = key_held;
  end

  task automatic clear_mon();
    vcnt = 0; vcyc = -1; hrise = -1; hfall = -1; hfall_cnt = 0; fidx = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    col   = 4'b1110;
    keys  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
  endtask

  // One scan frame of four 8-cycle phases; bad3 replaces the last phase with 1100.
  task automatic run_frame(input logic [15:0] k, input bit bad3, input int rst_at);
    logic [3:0] cv;
    fidx++;
    fs[fidx] = cyc;
    keys = k;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 8; c++) begin
        cv = 4'b1111;
        cv[p] = 1'b0;
        col = (p == 3 && bad3) ? 4'b1100 : cv;
        rst_n = !((p*8 + c) == rst_at);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; col = 4'b1110; keys = '0;
    repeat (3) @(negedge clk);
    tests++; if (key_code !== 4'h0) begin failed++; $display("FAIL rst_code: got %h expected 0", key_code); end
    tests++; if (key_valid !== 1'b0) begin failed++; $display("FAIL rst_valid: got %b expected 0", key_valid); end
    tests++; if (key_held !== 1'b0) begin failed++; $display("FAIL rst_held: got %b expected 0", key_held); end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 5; i++) run_frame(16'h0200, 1'b0, -1);
    tests++; if (key_held !== 1'b1) begin failed++; $display("FAIL hold_held_on: got %b expected 1", key_held); end
    for (int i = 0; i < 3; i++) run_frame(16'h0000, 1'b0, -1);
    tests++; if (key_held !== 1'b1) begin failed++; $display("FAIL hold_held_rel: got %b expected 1", key_held); end
    run_frame(16'h0000, 1'b0, -1);
    tests++; if (key_held !== 1'b0) begin failed++; $display("FAIL hold_held_off: got %b expected 0", key_held); end
    tests++; if (vcnt !== 1) begin failed++; $display("FAIL hold_vcnt: got %0d expected 1", vcnt); end
    tests++; if (key_code !== 4'h9) begin failed++; $display("FAIL hold_code: got %h expected 9", key_code); end
    tests++; if (vcyc !== fs[4] + 3) begin failed++; $display("FAIL hold_vtime: got %0d expected %0d", vcyc, fs[4] + 3); end
    tests++; if (hrise !== vcyc) begin failed++; $display("FAIL hold_rise: got %0d expected %0d", hrise, vcyc); end
    tests++; if (hfall !== fs[9] + 3) begin failed++; $display("FAIL hold_fall: got %0d expected %0d", hfall, fs[9] + 3); end
  endtask

  task automatic test_bounce();
    do_reset();
    run_frame(16'h0200, 1'b0, -1);
    run_frame(16'h0200, 1'b0, -1);
    run_frame(16'h0000, 1'b0, -1);
    for (int i = 0; i < 3; i++) run_frame(16'h0200, 1'b0, -1);
    for (int i = 0; i < 4; i++) run_frame(16'h0000, 1'b0, -1);
    tests++; if (vcnt !== 1) begin failed++; $display("FAIL bounce_vcnt: got %0d expected 1", vcnt); end
    tests++; if (key_code !== 4'h9) begin failed++; $display("FAIL bounce_code: got %h expected 9", key_code); end
    tests++; if (vcyc !== fs[7] + 3) begin failed++; $display("FAIL bounce_vtime: got %0d expected %0d", vcyc, fs[7] + 3); end
  endtask

  task automatic test_multi();
    do_reset();
    for (int i = 0; i < 6; i++) run_frame(16'h0021, 1'b0, -1);
    run_frame(16'h0000, 1'b0, -1);
    tests++; if (vcnt !== 0) begin failed++; $display("FAIL multi_vcnt: got %0d expected 0", vcnt); end
    tests++; if (hrise !== -1) begin failed++; $display("FAIL multi_held: rose at %0d expected never", hrise); end
    tests++; if (key_code !== 4'h0) begin failed++; $display("FAIL multi_code: got %h expected 0", key_code); end
  endtask

  task automatic test_repress();
    do_reset();
    for (int i = 0; i < 4; i++) run_frame(16'h8000, 1'b0, -1);
    run_frame(16'h0000, 1'b0, -1);
    run_frame(16'h8000, 1'b0, -1);
    run_frame(16'h8000, 1'b0, -1);
    for (int i = 0; i < 4; i++) run_frame(16'h0000, 1'b0, -1);
    tests++; if (vcnt !== 1) begin failed++; $display("FAIL repress_vcnt: got %0d expected 1", vcnt); end
    tests++; if (key_code !== 4'hF) begin failed++; $display("FAIL repress_code: got %h expected f", key_code); end
    tests++; if (hfall_cnt !== 1) begin failed++; $display("FAIL repress_falls: got %0d expected 1", hfall_cnt); end
    tests++; if (hfall !== fs[11] + 3) begin failed++; $display("FAIL repress_fall: got %0d expected %0d", hfall, fs[11] + 3); end
  endtask

  task automatic test_bad_col();
    do_reset();
    run_frame(16'h0040, 1'b0, -1);
    run_frame(16'h0040, 1'b1, -1);
    for (int i = 0; i < 3; i++) run_frame(16'h0040, 1'b0, -1);
    for (int i = 0; i < 4; i++) run_frame(16'h0000, 1'b0, -1);
    tests++; if (vcnt !== 1) begin failed++; $display("FAIL badcol_vcnt: got %0d expected 1", vcnt); end
    tests++; if (key_code !== 4'h6) begin failed++; $display("FAIL badcol_code: got %h expected 6", key_code); end
    tests++; if (vcyc !== fs[5] + 3) begin failed++; $display("FAIL badcol_vtime: got %0d expected %0d", vcyc, fs[5] + 3); end
  endtask

  task automatic test_mid_reset();
    clear_mon();
    run_frame(16'h0200, 1'b0, -1);
    run_frame(16'h0200, 1'b0, -1);
    run_frame(16'h0200, 1'b0, 12);
    tests++; if (key_code !== 4'h0) begin failed++; $display("FAIL midrst_code0: got %h expected 0", key_code); end
    tests++; if (key_held !== 1'b0) begin failed++; $display("FAIL midrst_held: got %b expected 0", key_held); end
    run_frame(16'h0200, 1'b0, -1);
    run_frame(16'h0200, 1'b0, -1);
    for (int i = 0; i < 4; i++) run_frame(16'h0000, 1'b0, -1);
    tests++; if (vcnt !== 1) begin failed++; $display("FAIL midrst_vcnt: got %0d expected 1", vcnt); end
    tests++; if (vcyc !== fs[6] + 3) begin failed++; $display("FAIL midrst_vtime: got %0d expected %0d", vcyc, fs[6] + 3); end
    tests++; if (key_code !== 4'h9) begin failed++; $display("FAIL midrst_code: got %h expected 9", key_code); end
  endtask

  initial begin
    tests = 0; failed = 0;
    rst_n = 1'b0; col = 4'b1110; keys = '0;
    clear_mon();
    @(negedge clk);
    test_reset();
    test_hold();
    test_bounce();
    test_multi();
    test_repress();
    test_bad_col();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
